// File: rtl/rgb_fx_if.sv
// Control and colour bundle between the effect engine and its driver.
// master drives mode/rate/freeze/enables; slave returns R/G/B/tick.
interface rgb_fx_if #(
  parameter int CW = 3,
  parameter int RW = 4
);
  logic [1:0]    mode;
  logic [RW-1:0] rate;
  logic          freeze;
  logic          Radd;
  logic          Gadd;
  logic          Badd;
  logic [CW-1:0] R;
  logic [CW-1:0] G;
  logic [CW-1:0] B;
  logic          tick;

  modport master (
    output mode, rate, freeze,
    output Radd, Gadd, Badd,
    input  R, G, B, tick
  );

  modport slave (
    input  mode, rate, freeze,
    input  Radd, Gadd, Badd,
    output R, G, B, tick
  );
endinterface

// File: rtl/rgb_fx_engine.sv
// Colour-effect generator: solid, blink, triangle fade, colour cycle.
// Ports: tenH_clk, reset (async high), fx (rgb_fx_if.slave).
module rgb_fx_engine #(
  parameter int CW = 3,
  parameter int RW = 4
) (
  input  logic    tenH_clk,
  input  logic    reset,
  rgb_fx_if.slave fx
);

  typedef enum logic [1:0] {
    M_SOLID = 2'b00,
    M_BLINK = 2'b01,
    M_FADE  = 2'b10,
    M_CYCLE = 2'b11
  } mode_t;

  typedef enum logic {
    D_UP   = 1'b0,
    D_DOWN = 1'b1
  } dir_t;

  localparam logic [CW-1:0] MAX = '1;

  logic [RW-1:0] cnt, cnt_n;
  logic [CW-1:0] lvl, lvl_n;
  dir_t          dir, dir_n;
  logic [2:0]    idx, idx_n;
  mode_t         mode_q, mode_n;

  logic          chg;
  logic          itick;
  logic [2:0]    en;
  logic [2:0]    msk;
  logic [CW-1:0] r_n, g_n, b_n;

  always_ff @(posedge tenH_clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      lvl    <= '0;
      dir    <= D_UP;
      idx    <= '0;
      mode_q <= M_SOLID;
      fx.R   <= '0;
      fx.G   <= '0;
      fx.B   <= '0;
      fx.tick <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      lvl    <= lvl_n;
      dir    <= dir_n;
      idx    <= idx_n;
      mode_q <= mode_n;
      fx.R   <= r_n;
      fx.G   <= g_n;
      fx.B   <= b_n;
      fx.tick <= itick;
    end
  end

  always_comb begin
    cnt_n  = cnt;
    lvl_n  = lvl;
    dir_n  = dir;
    idx_n  = idx;
    mode_n = mode_q;
    chg    = (mode_t'(fx.mode) != mode_q);
    itick  = 1'b0;

    if (chg) begin
      mode_n = mode_t'(fx.mode);
      cnt_n  = '0;
      dir_n  = D_UP;
      idx_n  = '0;
      lvl_n  = (mode_t'(fx.mode) == M_SOLID) ? MAX : '0;
    end else if (!fx.freeze) begin
      // >= so a rate lowered under cnt still ends the period next edge
      itick = (cnt >= fx.rate);
      cnt_n = itick ? '0 : cnt + RW'(1);
      unique case (1'b1)
        (mode_q == M_SOLID): lvl_n = MAX;
        (mode_q == M_BLINK): begin
          if (itick)
            lvl_n = (lvl == '0) ? MAX : '0;
        end
        (mode_q == M_FADE): begin
          if (itick) begin
            if (dir == D_UP) begin
              if (lvl == MAX) begin
                lvl_n = MAX - CW'(1);
                dir_n = D_DOWN;
              end else begin
                lvl_n = lvl + CW'(1);
              end
            end else begin
              if (lvl == '0) begin
                lvl_n = CW'(1);
                dir_n = D_UP;
              end else begin
                lvl_n = lvl - CW'(1);
              end
            end
          end
        end
        (mode_q == M_CYCLE): begin
          if (itick)
            idx_n = (idx == 3'd6) ? 3'd0 : idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    en  = {fx.Radd, fx.Gadd, fx.Badd};
    msk = (en == 3'b000) ? 3'b111 : en;
    r_n = '0;
    g_n = '0;
    b_n = '0;
    if (mode_n == M_CYCLE) begin
      unique case (idx_n)
        3'd0:    msk = 3'b100;
        3'd1:    msk = 3'b010;
        3'd2:    msk = 3'b001;
        3'd3:    msk = 3'b110;
        3'd4:    msk = 3'b011;
        3'd5:    msk = 3'b101;
        default: msk = 3'b111;
      endcase
      r_n = msk[2] ? MAX : '0;
      g_n = msk[1] ? MAX : '0;
      b_n = msk[0] ? MAX : '0;
    end else begin
      r_n = msk[2] ? lvl_n : '0;
      g_n = msk[1] ? lvl_n : '0;
      b_n = msk[0] ? lvl_n : '0;
    end
  end

endmodule

// File: tb/tb_rgb_fx_engine.sv
// Directed bench for rgb_fx_engine.
// Drives and samples on the falling edge of tenH_clk.
module tb_rgb_fx_engine;

  localparam int CW = 3;
  localparam int RW = 4;

  logic tenH_clk;
  logic reset;
  int   n_chk;
  int   n_err;

  rgb_fx_if #(.CW(CW), .RW(RW)) fx ();

  rgb_fx_engine #(.CW(CW), .RW(RW)) dut (
    .tenH_clk (tenH_clk),
    .reset    (reset),
    .fx       (fx.slave)
  );

  initial begin
    tenH_clk = 1'b0;
    forever #5 tenH_clk = ~tenH_clk;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge tenH_clk);
    @(negedge tenH_clk);
  endtask

  function automatic int rgb(input int m);
    return ((m & 4) ? 7 : 0) * 64 + ((m & 2) ? 7 : 0) * 8 + ((m & 1) ? 7 : 0);
  endfunction

  function automatic int obs_rgb();
    return int'(fx.R) * 64 + int'(fx.G) * 8 + int'(fx.B);
  endfunction

  int fade_seq [16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
  int cyc_msk  [8]  = '{4, 2, 1, 6, 3, 5, 7, 4};

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    fx.mode = 2'b00;
    fx.rate = 4'd2;
    fx.freeze = 1'b0;
    fx.Radd = 1'b1;
    fx.Gadd = 1'b0;
    fx.Badd = 1'b0;

    // 1: reset state, then SOLID red with rate 2
    @(negedge tenH_clk);
    chk("rst_rgb", obs_rgb(), 0);
    chk("rst_tick", int'(fx.tick), 0);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("solid_rgb", obs_rgb(), 7 * 64);
      chk("solid_tick", int'(fx.tick), (k % 3 == 2) ? 1 : 0);
    end

    // 2: BLINK, rate 0, white default
    fx.mode = 2'b01;
    fx.rate = 4'd0;
    fx.Radd = 1'b0;
    step();
    chk("blink_chg_rgb", obs_rgb(), 0);
    chk("blink_chg_tick", int'(fx.tick), 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("blink_rgb", obs_rgb(), (k % 2 == 1) ? rgb(7) : 0);
      chk("blink_tick", int'(fx.tick), 1);
    end

    // 3: FADE on green, full triangle period
    fx.mode = 2'b10;
    fx.Gadd = 1'b1;
    step();
    chk("fade_chg_g", int'(fx.G), 0);
    chk("fade_chg_tick", int'(fx.tick), 0);
    for (int k = 0; k < 16; k++) begin
      step();
      chk("fade_rgb", obs_rgb(), fade_seq[k] * 8);
    end

    // 4: CYCLE, rate 1, enables ignored
    fx.mode = 2'b11;
    fx.rate = 4'd1;
    fx.Radd = 1'b1;
    fx.Gadd = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      chk("cycle_rgb", obs_rgb(), rgb(cyc_msk[k / 2]));
      chk("cycle_tick", int'(fx.tick), (k > 0 && k % 2 == 0) ? 1 : 0);
      if (k == 5) fx.Badd = 1'b1;
      if (k == 9) fx.Radd = 1'b0;
    end

    // 5: freeze in FADE at L=4 going up
    fx.mode = 2'b10;
    fx.rate = 4'd0;
    fx.Radd = 1'b0;
    fx.Gadd = 1'b1;
    fx.Badd = 1'b0;
    step();
    chk("frz_chg_g", int'(fx.G), 0);
    for (int k = 1; k <= 4; k++) step();
    chk("frz_pre_g", int'(fx.G), 4);
    fx.freeze = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("frz_hold_g", int'(fx.G), 4);
      chk("frz_tick", int'(fx.tick), 0);
    end
    fx.freeze = 1'b0;
    step();
    chk("frz_resume_g", int'(fx.G), 5);
    chk("frz_resume_tick", int'(fx.tick), 1);
    fx.freeze = 1'b1;
    fx.mode = 2'b01;
    fx.rate = 4'd2;
    step();
    chk("frz_chg_g", int'(fx.G), 0);
    chk("frz_chg_tick", int'(fx.tick), 0);
    step();
    chk("frz_blink_g", int'(fx.G), 0);
    fx.freeze = 1'b0;
    step();
    chk("post_frz_g0", int'(fx.G), 0);
    chk("post_frz_t0", int'(fx.tick), 0);
    step();
    chk("post_frz_g1", int'(fx.G), 0);
    step();
    chk("post_frz_g2", int'(fx.G), 7);
    chk("post_frz_t2", int'(fx.tick), 1);

    // 6: async reset at L=5 going down
    fx.mode = 2'b10;
    fx.rate = 4'd0;
    step();
    for (int k = 0; k < 9; k++) step();
    chk("mid_g", int'(fx.G), 5);
    chk("mid_tick", int'(fx.tick), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rgb", obs_rgb(), 0);
    chk("async_tick", int'(fx.tick), 0);
    @(negedge tenH_clk);
    reset = 1'b0;
    step();
    chk("rel_chg_g", int'(fx.G), 0);
    chk("rel_chg_tick", int'(fx.tick), 0);
    step();
    chk("rel_first_g", int'(fx.G), 1);
    chk("rel_first_tick", int'(fx.tick), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rgb_fx_engine.md
Name: rgb_fx_engine

Overview:
Parametrised colour-effect generator for the VGA colour path. It produces per-channel intensity words R/G/B in four modes: solid, blink, triangle fade and colour cycle. Effect timing comes from a programmable prescaler on the slow effect clock. Outputs feed the pixel-clock colour mux, which applies display-area and pixel gating downstream.

Parameters:
CW, 3, bits per colour channel; MAX = 2^CW-1
RW, 4, width of rate input / prescaler counter

Ports:
tenH_clk  in  1  effect clock; all state on rising edge
reset  in  1  asynchronous, active-high; clock tenH_clk
mode  in  2  00 SOLID, 01 BLINK, 10 FADE, 11 CYCLE
rate  in  RW  prescaler terminal value; effect tick every rate+1 cycles
freeze  in  1  hold all effect state (prescaler, level, direction, index)
Radd  in  1  red channel enable
Gadd  in  1  green channel enable
Badd  in  1  blue channel enable
R  out  CW  red intensity, registered
G  out  CW  green intensity, registered
B  out  CW  blue intensity, registered
tick  out  1  registered one-cycle pulse on each effect step

Behaviour:
- Reset (async) values: cnt=0, L=0, dir=up, idx=0, mode_q=00, R=G=B=0, tick=0.
- Prescaler:
  - If cnt>=rate: internal tick, cnt<=0.
  - Else cnt<=cnt+1.
  - rate=0 gives a tick every cycle.
  - If rate is lowered below cnt, the tick fires on the next edge (>= compare).
- freeze=1: cnt, L, dir and idx hold; no internal tick; tick output=0; R/G/B still recomputed from held state and current enables.
- Mode change (mode!=mode_q):
  - mode_q<=mode, cnt<=0, dir<=up, idx<=0.
  - L<=MAX if the new mode is SOLID, else 0.
  - No tick that cycle.
  - Mode change takes priority over freeze.
- SOLID: L<=MAX every cycle; ticks still pulse.
- BLINK: on tick, L<=(L==0)?MAX:0.
- FADE, on tick (triangle wave):
  - dir=up: if L==MAX then L<=MAX-1, dir<=down; else L<=L+1.
  - dir=down: if L==0 then L<=1, dir<=up; else L<=L-1.
  - Sequence from 0: 0,1,...,MAX,MAX-1,...,0,1...
  - MAX is held exactly one step; 0 is held exactly one step.
- CYCLE:
  - On tick, idx<=(idx==6)?0:idx+1.
  - Colour mask per idx (R,G,B): 0:100, 1:010, 2:001, 3:110, 4:011, 5:101, 6:111.
  - Channel level = MAX for set bits, 0 otherwise.
  - Radd/Gadd/Badd are ignored in CYCLE.
- Channel mask (SOLID/BLINK/FADE):
  - {Radd,Gadd,Badd}; if all zero, mask=111 (white default).
  - Channel = mask bit ? L_next : 0.
- Output timing:
  - R/G/B register at the same edge as the state update, from next-state values.
  - Enable or level changes are visible one edge after they are sampled.
  - tick output registers the internal tick (same edge as the level step).
- Widths:
  - L is CW bits; all compares are against MAX.
  - No wrap of L beyond 0..MAX.
  - cnt is RW bits and never exceeds the rate+1 terminal.
- Reset mid-effect: all outputs go 0 immediately (async). On the first edge after release, operation is as from power-up (mode_q=00, so SOLID needs no mode-change cycle).

Test Plan:
1. CW=3, rate=2, mode=00, Radd=1, Gadd=Badd=0, release reset -> after 1st edge R=7, G=B=0; tick pulses every 3 cycles.
2. mode=01, rate=0, all enables 0 -> R=G=B alternate 7,0,7,0 each cycle after the mode-change cycle (first value 0); tick=1 every cycle except the change cycle.
3. mode=10, rate=0, Gadd=1 -> G follows 0,1,2,...,7,6,...,0,1 with exactly one 7 and one 0 per period (14 steps); R=B=0.
4. mode=11, rate=1, Radd=1 -> R/G/B masks follow 100,010,001,110,011,101,111,100 every 2 cycles; enables have no effect.
5. FADE at L=4 up, assert freeze 5 cycles, then deassert -> L holds 4 with tick=0 during freeze, then resumes at 5; change mode to BLINK while frozen -> L=0, idx=0, cnt=0.
6. Assert reset mid-FADE (L=5, down) between edges -> R/G/B=0 and tick=0 immediately; after release with mode=10, first effect step is L=1.
